// File: rtl/prio_enc_pkg.sv
// Shared constants and helpers for the priority encoder controller.
// Priority modes and index-width calculation.
package prio_enc_pkg;

    localparam int PRIO_LSB = 0;
    localparam int PRIO_MSB = 1;
    localparam int PRIO_RR  = 2;

    // Index width that never collapses to zero bits.
    function automatic int idx_width(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/prio_scan.sv
// Combinational priority scan over a request vector.
// Fixed LSB/MSB priority, or rotating scan from a start position.
module prio_scan
    import prio_enc_pkg::*;
#(
    parameter int N    = 8,
    parameter int MODE = PRIO_LSB,
    localparam int W   = idx_width(N)
) (
    input  logic [N-1:0] vec,
    input  logic [W-1:0] start,
    output logic         found,
    output logic [W-1:0] pos
);

    logic [N-1:0] rot;
    logic [W:0]   sum;
    int           k;
    logic         unused_start;

    assign unused_start = ^start;

    // Select one set bit of vec according to the priority mode.
    always_comb begin
        found = |vec;
        pos   = '0;
        rot   = '0;
        sum   = '0;
        k     = 0;
        if (MODE == PRIO_RR) begin
            rot = N'({vec, vec} >> start);
            for (int i = N - 1; i >= 0; i--) begin
                if (rot[i]) k = i;
            end
            sum = {1'b0, start} + (W + 1)'(k);
            if (sum >= (W + 1)'(N)) sum = sum - (W + 1)'(N);
            pos = sum[W-1:0];
        end else if (MODE == PRIO_MSB) begin
            for (int i = 0; i < N; i++) begin
                if (vec[i]) pos = W'(i);
            end
        end else begin
            for (int i = N - 1; i >= 0; i--) begin
                if (vec[i]) pos = W'(i);
            end
        end
    end

endmodule

// File: rtl/prio_enc_ctrl.sv
// Registered priority encoder with sticky capture and valid/ready output.
// One pending line is issued per handshake and cleared on acceptance.
module prio_enc_ctrl
    import prio_enc_pkg::*;
#(
    parameter int N    = 8,
    parameter int MODE = PRIO_LSB,
    localparam int W   = idx_width(N)
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [N-1:0] req,
    input  logic [N-1:0] en,
    input  logic         out_ready,
    output logic         out_valid,
    output logic [W-1:0] idx,
    output logic [N-1:0] pending
);

    logic         hs;
    logic [N-1:0] clr;
    logic [N-1:0] cand;
    logic [W-1:0] ptr;
    logic [W-1:0] start;
    logic [W-1:0] pos;
    logic         found;

    assign hs    = out_valid & out_ready;
    assign clr   = hs ? (N'(1) << idx) : '0;
    assign cand  = pending & en & ~clr;
    assign start = (ptr == W'(N - 1)) ? '0 : ptr + 1'b1;

    prio_scan #(
        .N    (N),
        .MODE (MODE)
    ) u_scan (
        .vec   (cand),
        .start (start),
        .found (found),
        .pos   (pos)
    );

    // Sticky capture; a same-cycle request re-sets the accepted bit.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) pending <= '0;
        else     pending <= (pending & ~clr) | req;
    end

    // Output register reloads when empty or when the index is taken.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_valid <= 1'b0;
            idx       <= '0;
        end else if (!out_valid || hs) begin
            out_valid <= found;
            idx       <= found ? pos : '0;
        end
    end

    // Round-robin pointer tracks the last accepted line.
    always_ff @(posedge clk or posedge rst) begin
        if (rst)     ptr <= W'(N - 1);
        else if (hs) ptr <= idx;
    end

endmodule

// File: tb/tb_prio_enc_ctrl.sv
// Self-checking bench: LSB, MSB and round-robin instances plus N=5.
// Expected indices are queued at stimulus time and popped on handshake.
module tb_prio_enc_ctrl;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [7:0] req0 = '0, en0 = 8'hFF;
    logic [7:0] req1 = '0, en1 = 8'hFF;
    logic [7:0] req2 = '0, en2 = 8'hFF;
    logic [4:0] req3 = '0, en3 = 5'h1F;
    logic       rdy0 = 1'b0, rdy1 = 1'b0, rdy2 = 1'b0, rdy3 = 1'b0;
    logic       v0, v1, v2, v3;
    logic [2:0] i0, i1, i2, i3;
    logic [7:0] p0, p1, p2;
    logic [4:0] p3;

    int checks = 0;
    int errors = 0;
    int exp_q[$];

    always #5 clk = ~clk;

    prio_enc_ctrl #(.N(8), .MODE(0)) u0 (
        .clk(clk), .rst(rst), .req(req0), .en(en0), .out_ready(rdy0),
        .out_valid(v0), .idx(i0), .pending(p0)
    );
    prio_enc_ctrl #(.N(8), .MODE(1)) u1 (
        .clk(clk), .rst(rst), .req(req1), .en(en1), .out_ready(rdy1),
        .out_valid(v1), .idx(i1), .pending(p1)
    );
    prio_enc_ctrl #(.N(8), .MODE(2)) u2 (
        .clk(clk), .rst(rst), .req(req2), .en(en2), .out_ready(rdy2),
        .out_valid(v2), .idx(i2), .pending(p2)
    );
    prio_enc_ctrl #(.N(5), .MODE(2)) u3 (
        .clk(clk), .rst(rst), .req(req3), .en(en3), .out_ready(rdy3),
        .out_valid(v3), .idx(i3), .pending(p3)
    );

    task automatic do_reset();
        rst = 1'b1;
        req0 = '0; req1 = '0; req2 = '0; req3 = '0;
        en0 = 8'hFF; en1 = 8'hFF; en2 = 8'hFF; en3 = 5'h1F;
        rdy0 = 0; rdy1 = 0; rdy2 = 0; rdy3 = 0;
        exp_q.delete();
        repeat (2) @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_reset();
        do_reset();
        checks++;
        if (v0 !== 1'b0 || i0 !== 3'd0 || p0 !== 8'h00) begin
            errors++;
            $display("FAIL reset_state: valid=%b idx=%0d pend=%h want 0/0/00",
                     v0, i0, p0);
        end
        req0 = 8'h10;
        @(negedge clk);
        req0 = 8'h00;
        @(negedge clk);
        checks++;
        if (v0 !== 1'b1 || i0 !== 3'd4) begin
            errors++;
            $display("FAIL reset_pre: valid=%b idx=%0d want 1/4", v0, i0);
        end
        #2 rst = 1'b1;
        #1;
        checks++;
        if (v0 !== 1'b0 || i0 !== 3'd0 || p0 !== 8'h00) begin
            errors++;
            $display("FAIL reset_async: valid=%b idx=%0d pend=%h want 0/0/00",
                     v0, i0, p0);
        end
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_lsb();
        int e;
        do_reset();
        rdy0 = 1'b1;
        req0 = 8'b0010_0100;
        exp_q.push_back(2);
        exp_q.push_back(5);
        @(negedge clk);
        req0 = '0;
        checks++;
        if (v0 !== 1'b0) begin
            errors++;
            $display("FAIL lsb_latency1: valid=%b want 0", v0);
        end
        @(negedge clk);
        checks++;
        if (v0 !== 1'b1) begin
            errors++;
            $display("FAIL lsb_latency2: valid=%b want 1", v0);
        end
        for (int c = 0; c < 20 && exp_q.size() > 0; c++) begin
            if (v0 && rdy0) begin
                e = exp_q.pop_front();
                checks++;
                if (i0 !== 3'(e)) begin
                    errors++;
                    $display("FAIL lsb_idx: got %0d want %0d", i0, e);
                end
            end
            if (exp_q.size() > 0) @(negedge clk);
        end
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL lsb_timeout: %0d left want 0", exp_q.size());
            exp_q.delete();
        end
        @(negedge clk);
        checks++;
        if (v0 !== 1'b0 || p0 !== 8'h00) begin
            errors++;
            $display("FAIL lsb_idle: valid=%b pend=%h want 0/00", v0, p0);
        end
    endtask

    task automatic test_msb_hold();
        int e;
        do_reset();
        req1 = 8'b1000_0001;
        exp_q.push_back(7);
        exp_q.push_back(0);
        @(negedge clk);
        req1 = '0;
        @(negedge clk);
        for (int c = 0; c < 5; c++) begin
            checks++;
            if (v1 !== 1'b1 || i1 !== 3'd7) begin
                errors++;
                $display("FAIL msb_hold: valid=%b idx=%0d want 1/7", v1, i1);
            end
            if (c < 4) @(negedge clk);
        end
        rdy1 = 1'b1;
        for (int c = 0; c < 20 && exp_q.size() > 0; c++) begin
            if (v1 && rdy1) begin
                e = exp_q.pop_front();
                checks++;
                if (i1 !== 3'(e)) begin
                    errors++;
                    $display("FAIL msb_idx: got %0d want %0d", i1, e);
                end
            end
            if (exp_q.size() > 0) @(negedge clk);
        end
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL msb_timeout: %0d left want 0", exp_q.size());
            exp_q.delete();
        end
        @(negedge clk);
        checks++;
        if (v1 !== 1'b0 || p1 !== 8'h00) begin
            errors++;
            $display("FAIL msb_idle: valid=%b pend=%h want 0/00", v1, p1);
        end
    endtask

    task automatic test_back_to_back();
        int e;
        do_reset();
        rdy2 = 1'b1;
        req2 = 8'hFF;
        for (int k = 0; k < 10; k++) exp_q.push_back(k % 8);
        for (int c = 0; c < 30 && exp_q.size() > 0; c++) begin
            if (v2 && rdy2) begin
                e = exp_q.pop_front();
                checks++;
                if (i2 !== 3'(e)) begin
                    errors++;
                    $display("FAIL rr_idx: got %0d want %0d", i2, e);
                end
            end
            if (exp_q.size() > 0) @(negedge clk);
        end
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL rr_timeout: %0d left want 0", exp_q.size());
            exp_q.delete();
        end
        checks++;
        if (p2 !== 8'hFF) begin
            errors++;
            $display("FAIL rr_setwins: pend=%h want ff", p2);
        end
    endtask

    task automatic test_rr_n5();
        int e;
        do_reset();
        rdy3 = 1'b1;
        req3 = 5'h1F;
        for (int k = 0; k < 7; k++) exp_q.push_back(k % 5);
        for (int c = 0; c < 30 && exp_q.size() > 0; c++) begin
            if (v3 && rdy3) begin
                e = exp_q.pop_front();
                checks++;
                if (i3 !== 3'(e)) begin
                    errors++;
                    $display("FAIL n5_idx: got %0d want %0d", i3, e);
                end
            end
            if (exp_q.size() > 0) @(negedge clk);
        end
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL n5_timeout: %0d left want 0", exp_q.size());
            exp_q.delete();
        end
    endtask

    task automatic test_enable();
        int e;
        do_reset();
        rdy0 = 1'b1;
        en0 = 8'b0000_0010;
        req0 = 8'b0000_0011;
        exp_q.push_back(1);
        @(negedge clk);
        req0 = '0;
        for (int c = 0; c < 20 && exp_q.size() > 0; c++) begin
            if (v0 && rdy0) begin
                e = exp_q.pop_front();
                checks++;
                if (i0 !== 3'(e)) begin
                    errors++;
                    $display("FAIL en_idx: got %0d want %0d", i0, e);
                end
            end
            if (exp_q.size() > 0) @(negedge clk);
        end
        @(negedge clk);
        @(negedge clk);
        checks++;
        if (v0 !== 1'b0 || p0 !== 8'h01) begin
            errors++;
            $display("FAIL en_masked: valid=%b pend=%h want 0/01", v0, p0);
        end
        en0 = 8'hFF;
        exp_q.push_back(0);
        for (int c = 0; c < 20 && exp_q.size() > 0; c++) begin
            if (v0 && rdy0) begin
                e = exp_q.pop_front();
                checks++;
                if (i0 !== 3'(e)) begin
                    errors++;
                    $display("FAIL en_release: got %0d want %0d", i0, e);
                end
            end
            if (exp_q.size() > 0) @(negedge clk);
        end
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL en_timeout: %0d left want 0", exp_q.size());
            exp_q.delete();
        end
        @(negedge clk);
        checks++;
        if (p0 !== 8'h00) begin
            errors++;
            $display("FAIL en_final: pend=%h want 00", p0);
        end
    endtask

    task automatic test_hold_setwins();
        int e;
        do_reset();
        req0 = 8'h08;
        @(negedge clk);
        req0 = '0;
        @(negedge clk);
        en0 = 8'hF7;
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            checks++;
            if (v0 !== 1'b1 || i0 !== 3'd3) begin
                errors++;
                $display("FAIL hold_en: valid=%b idx=%0d want 1/3", v0, i0);
            end
        end
        exp_q.push_back(3);
        exp_q.push_back(3);
        en0 = 8'hFF;
        req0 = 8'h08;
        rdy0 = 1'b1;
        e = exp_q.pop_front();
        checks++;
        if (v0 !== 1'b1 || i0 !== 3'(e)) begin
            errors++;
            $display("FAIL hold_accept: valid=%b idx=%0d want 1/%0d",
                     v0, i0, e);
        end
        @(negedge clk);
        req0 = '0;
        checks++;
        if (p0[3] !== 1'b1 || v0 !== 1'b0) begin
            errors++;
            $display("FAIL setwins_pend: pend=%h valid=%b want bit3/0",
                     p0, v0);
        end
        for (int c = 0; c < 20 && exp_q.size() > 0; c++) begin
            if (v0 && rdy0) begin
                e = exp_q.pop_front();
                checks++;
                if (i0 !== 3'(e)) begin
                    errors++;
                    $display("FAIL reissue_idx: got %0d want %0d", i0, e);
                end
            end
            if (exp_q.size() > 0) @(negedge clk);
        end
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL reissue_timeout: %0d left want 0", exp_q.size());
            exp_q.delete();
        end
        @(negedge clk);
        checks++;
        if (v0 !== 1'b0 || p0 !== 8'h00) begin
            errors++;
            $display("FAIL reissue_idle: valid=%b pend=%h want 0/00", v0, p0);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_lsb();
        test_msb_hold();
        test_back_to_back();
        test_rr_n5();
        test_enable();
        test_hold_setwins();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
